// File: rtl/seq_ctrl.sv
// Run/pause/step sequence controller producing binary up/down, Gray or Johnson
// sequences on a registered 4-bit output, with an optional per-run advance limit.
module seq_ctrl (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic [1:0] mode,
    input  logic [3:0] limit,
    output logic [3:0] c,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] c_reg, c_next;
    logic [3:0] b_reg, b_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [1:0] mode_reg, mode_next;
    logic [3:0] limit_reg, limit_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;

    // Candidate values for one advance of the latched sequence
    logic [3:0] c_adv;
    logic [3:0] b_inc;
    logic [3:0] gray_adv;
    logic [3:0] cnt_inc;
    logic       limit_hit;

    assign b_inc   = b_reg + 4'd1;
    assign cnt_inc = cnt_reg + 4'd1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_gray
            assign gray_adv[gi] = b_inc[gi] ^ b_inc[gi+1];
        end
    endgenerate
    assign gray_adv[3] = b_inc[3];

    always_comb begin
        c_adv = c_reg;
        case (mode_reg)
            2'b00:   c_adv = c_reg + 4'd1;
            2'b01:   c_adv = c_reg - 4'd1;
            2'b10:   c_adv = gray_adv;
            default: c_adv = {c_reg[2:0], ~c_reg[3]};
        endcase
    end

    // A zero limit means free-run, so the wrapped count never terminates the run
    assign limit_hit = (limit_reg != 4'd0) && (cnt_inc == limit_reg);

    // State and datapath register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= S_IDLE;
            c_reg     <= 4'd0;
            b_reg     <= 4'd0;
            cnt_reg   <= 4'd0;
            mode_reg  <= 2'b00;
            limit_reg <= 4'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            c_reg     <= c_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            limit_reg <= limit_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state_reg;
        c_next     = c_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        limit_next = limit_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    mode_next  = mode;
                    limit_next = limit;
                    c_next     = (mode == 2'b01) ? 4'hF : 4'h0;
                    b_next     = 4'd0;
                    cnt_next   = 4'd0;
                end
            end
            S_RUN: begin
                // A limit hit takes precedence over a simultaneous stop
                if (limit_hit || !stop) begin
                    c_next   = c_adv;
                    b_next   = b_inc;
                    cnt_next = cnt_inc;
                    if (limit_hit) state_next = S_DONE;
                end else begin
                    state_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else if (start) begin
                    state_next = S_RUN;
                end else if (step) begin
                    c_next   = c_adv;
                    b_next   = b_inc;
                    cnt_next = cnt_inc;
                    if (limit_hit) state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Status flags are registered from the upcoming state
    always_comb begin
        busy_next = (state_next == S_RUN) || (state_next == S_PAUSE);
        done_next = (state_next == S_DONE);
    end

    assign c     = c_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: runs each sequence mode, pause/step, collisions
// and reset cases, checking {state, c, busy, done} after every edge.
module tb_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       stop;
    logic       step;
    logic [1:0] mode;
    logic [3:0] limit;
    logic [3:0] c;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11;

    seq_ctrl dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .stop  (stop),
        .step  (step),
        .mode  (mode),
        .limit (limit),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] exp_state, input logic [3:0] exp_c);
        logic [7:0] obs;
        logic [7:0] expv;
        obs  = {state, c, busy, done};
        expv = {exp_state, exp_c, (exp_state == RUN) || (exp_state == PAUSE), exp_state == DONE};
        n_assert++;
        assert (obs === expv)
            else begin
                n_fail++;
                $error("FAIL %s: observed state=%b c=%h busy=%b done=%b, expected state=%b c=%h busy=%b done=%b",
                       tag, obs[7:6], obs[5:2], obs[1], obs[0], expv[7:6], expv[5:2], expv[1], expv[0]);
            end
        $display("%0t %s state=%b c=%h busy=%b done=%b", $time, tag, state, c, busy, done);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; mode = 2'b00; limit = 4'd0;
        tick();
        tick();
        check("reset", IDLE, 4'h0);
        clr = 1'b0;
        tick();
        check("idle_hold", IDLE, 4'h0);

        // Binary up, limit 5; mode/limit changed after start must be ignored
        mode = 2'b00; limit = 4'd5; start = 1'b1;
        tick();
        start = 1'b0; mode = 2'b01; limit = 4'd0;
        check("up_start", RUN, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("up_run", RUN, 4'(i));
        end
        tick();
        check("up_done", DONE, 4'h5);
        tick();
        check("up_idle", IDLE, 4'h5);
        tick();
        check("up_idle_hold", IDLE, 4'h5);

        // Binary down, free-run through the wrap, then pause/resume/stop
        mode = 2'b01; limit = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("dn_start", RUN, 4'hF);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("dn_run", RUN, 4'(15 - i));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("dn_pause", PAUSE, 4'hF);
        tick();
        check("dn_pause_hold", PAUSE, 4'hF);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("dn_resume", RUN, 4'hF);
        tick();
        check("dn_resume_adv", RUN, 4'hE);
        stop = 1'b1;
        tick();
        check("dn_pause2", PAUSE, 4'hE);
        tick();
        stop = 1'b0;
        check("dn_stop_idle", IDLE, 4'hE);

        // Gray up, limit 15
        mode = 2'b10; limit = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        check("gray_start", RUN, gray_tab[0]);
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("gray_run", RUN, gray_tab[i]);
        end
        tick();
        check("gray_done", DONE, 4'h8);
        tick();
        check("gray_idle", IDLE, 4'h8);

        // Johnson with pause and single steps, limit 3
        mode = 2'b11; limit = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("john_start", RUN, 4'h0);
        tick();
        check("john_run", RUN, 4'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("john_pause", PAUSE, 4'h1);
        tick();
        check("john_pause_hold", PAUSE, 4'h1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("john_step1", PAUSE, 4'h3);
        tick();
        check("john_step_hold", PAUSE, 4'h3);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("john_step_done", DONE, 4'h7);
        tick();
        check("john_idle", IDLE, 4'h7);

        // Reset mid-run with start held high
        mode = 2'b00; limit = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_start", RUN, 4'h0);
        for (int i = 1; i <= 6; i++) tick();
        check("rst_at6", RUN, 4'h6);
        clr = 1'b1; start = 1'b1;
        tick();
        check("rst_mid_run", IDLE, 4'h0);
        tick();
        check("rst_held", IDLE, 4'h0);
        clr = 1'b0; start = 1'b0;
        tick();
        check("rst_release", IDLE, 4'h0);

        // Limit hit coincident with stop: DONE wins
        mode = 2'b00; limit = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("col_start", RUN, 4'h0);
        tick();
        check("col_run", RUN, 4'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("col_done", DONE, 4'h2);
        tick();
        check("col_idle", IDLE, 4'h2);

        // Reset during DONE
        mode = 2'b00; limit = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("rdone_start", RUN, 4'h0);
        tick();
        check("rdone_done", DONE, 4'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("rdone_clr", IDLE, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
